// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Optional dimming is enabled by defining SEVEN_SEG_DIM_EN (see seven_seg_scan_driver).
package seven_seg_pkg;

    // Active-high glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    function automatic logic [7:0] applyPolarity(input logic [7:0] activeHigh, input logic activeLow);
        return activeLow ? ~activeHigh : activeHigh;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph (a = bit0).
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with blank time, leading-zero blanking
// and frame-boundary display updates. Define SEVEN_SEG_DIM_EN to add the brightness input.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             SEG_LOW    = (SEG_ACTIVE_LOW != 0);
    localparam logic             DIG_LOW    = (DIG_ACTIVE_LOW != 0);
    localparam logic [7:0]       SEG_ALL_OFF = applyPolarity(8'h00, SEG_LOW);
    localparam logic [NUM_DIGITS-1:0] DIG_ALL_OFF = {NUM_DIGITS{DIG_LOW}};

    logic [CNT_W-1:0]        slotCnt_q, slotCnt_d;
    logic [IDX_W-1:0]        digIdx_q, digIdx_d;
    logic [4*NUM_DIGITS-1:0] shadowVal_q, shadowVal_d;
    logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
    logic [4*NUM_DIGITS-1:0] dispVal_q, dispVal_d;
    logic [NUM_DIGITS-1:0]   dispDp_q, dispDp_d;
    logic                    pending_q, pending_d;
    logic [7:0]              segOut_q, segOut_d;
    logic [NUM_DIGITS-1:0]   digEn_q, digEn_d;
    logic                    frameDone_q, frameDone_d;

    logic                    slotEnd;
    logic                    frameEnd;
    logic [3:0]              curNibble;
    logic                    curDp;
    logic [6:0]              decSeg;
    logic [NUM_DIGITS-1:0]   lzBlank;
    logic                    upperZero;
    logic                    digOn;
    logic [7:0]              segActive;
    logic [NUM_DIGITS-1:0]   digOneHot;

    assign curNibble = dispVal_q[{digIdx_q, 2'b00} +: 4];
    assign curDp     = dispDp_q[digIdx_q];

    seven_seg_hex_decoder u_decoder (
        .nibble_i (curNibble),
        .seg_o    (decSeg)
    );

    // Digit i is a leading zero when it and every more significant nibble are zero
    always_comb begin
        upperZero = 1'b1;
        lzBlank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upperZero  = upperZero & (dispVal_q[4*i +: 4] == 4'h0);
            lzBlank[i] = upperZero;
        end
    end

`ifdef SEVEN_SEG_DIM_EN
    logic [CNT_W+3:0] cntExt;
    assign cntExt = {4'b0000, slotCnt_q};
    assign digOn  = (slotCnt_q >= BLANK_END) && (cntExt[3:0] < brightness);
`else
    assign digOn  = (slotCnt_q >= BLANK_END);
`endif

    always_comb begin
        slotEnd     = (slotCnt_q == CNT_LAST);
        frameEnd    = slotEnd && (digIdx_q == IDX_LAST);
        slotCnt_d   = slotEnd ? '0 : slotCnt_q + 1'b1;
        digIdx_d    = digIdx_q;
        shadowVal_d = shadowVal_q;
        shadowDp_d  = shadowDp_q;
        dispVal_d   = dispVal_q;
        dispDp_d    = dispDp_q;
        pending_d   = pending_q;
        frameDone_d = frameEnd;

        if (slotEnd) begin
            digIdx_d = (digIdx_q == IDX_LAST) ? '0 : digIdx_q + 1'b1;
        end

        // A load on the boundary cycle still hands the old shadow to the display
        if (frameEnd && pending_q) begin
            dispVal_d = shadowVal_q;
            dispDp_d  = shadowDp_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadowVal_d = value_in;
            shadowDp_d  = dp_in;
            pending_d   = 1'b1;
        end

        segActive             = '0;
        segActive[SEG_DP_BIT] = curDp;
        segActive[SEG_G_BIT:SEG_A_BIT] = (blank_lz && lzBlank[digIdx_q]) ? SEG_OFF : decSeg;
        digOneHot             = NUM_DIGITS'(1) << digIdx_q;

        segOut_d = digOn ? applyPolarity(segActive, SEG_LOW) : SEG_ALL_OFF;
        digEn_d  = digOn ? (digOneHot ^ DIG_ALL_OFF) : DIG_ALL_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotCnt_q   <= '0;
            digIdx_q    <= '0;
            shadowVal_q <= '0;
            shadowDp_q  <= '0;
            dispVal_q   <= '0;
            dispDp_q    <= '0;
            pending_q   <= 1'b0;
            segOut_q    <= SEG_ALL_OFF;
            digEn_q     <= DIG_ALL_OFF;
            frameDone_q <= 1'b0;
        end else begin
            slotCnt_q   <= slotCnt_d;
            digIdx_q    <= digIdx_d;
            shadowVal_q <= shadowVal_d;
            shadowDp_q  <= shadowDp_d;
            dispVal_q   <= dispVal_d;
            dispDp_q    <= dispDp_d;
            pending_q   <= pending_d;
            segOut_q    <= segOut_d;
            digEn_q     <= digEn_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign seg_out    = segOut_q;
    assign dig_en     = digEn_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed, table-driven bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
// With SEVEN_SEG_DIM_EN defined it also checks dimming on a second instance.
module tb_seven_seg_scan_driver;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][7:0] seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] valueIn = '0;
    logic [3:0]  dpIn = '0;
    logic        load = 1'b0;
    logic        blankLz = 1'b0;
    logic [7:0]  segOut;
    logic [3:0]  digEn;
    logic        frameDone;

    int cmpCount = 0;
    int failCount = 0;
    int ft = 0;

    logic [7:0] decTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

`ifdef SEVEN_SEG_DIM_EN
    logic [3:0] mainBright = 4'hF;
    logic [3:0] dimBright  = 4'h4;
    logic [7:0] dimSeg;
    logic [3:0] dimDig;
    logic       dimFrame;

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(32), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dimDut (
        .clk(clk), .rst(rst), .value_in(16'h8888), .dp_in(4'h0), .load(1'b0), .blank_lz(1'b0),
        .brightness(dimBright), .seg_out(dimSeg), .dig_en(dimDig), .frame_done(dimFrame)
    );
`endif

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value_in(valueIn), .dp_in(dpIn), .load(load), .blank_lz(blankLz),
`ifdef SEVEN_SEG_DIM_EN
        .brightness(mainBright),
`endif
        .seg_out(segOut), .dig_en(digEn), .frame_done(frameDone)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        cmpCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ft++;
    endtask

    task automatic advanceTo(input int target);
        while (ft < target) tick();
    endtask

    // The boundary pulse is expected exactly 16 cycles after the previous one
    task automatic nextFrame(input string name);
        advanceTo(16);
        checkOutput({name, "/frame_done"}, 32'(frameDone), 32'h1);
        ft = 0;
    endtask

    task automatic waitFrameDone(input string name, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (frameDone !== 1'b1 && waited < 40);
        checkOutput({name, "/sync"}, 32'(frameDone), 32'h1);
        ft = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        valueIn = v.value;
        dpIn    = v.dp;
        blankLz = v.blz;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic checkDigit(input string name, input int d, input logic [7:0] expSeg);
        advanceTo(4*d + 3);
        checkOutput($sformatf("%s/d%0d_seg", name, d), 32'(segOut), 32'(expSeg));
        checkOutput($sformatf("%s/d%0d_en", name, d), 32'(digEn), 32'(~(4'b0001 << d) & 4'hF));
    endtask

    task automatic checkFrame(input string name, input logic [3:0][7:0] expSeg);
        for (int d = 0; d < 4; d++) begin
            advanceTo(4*d + 1);
            checkOutput($sformatf("%s/d%0d_blank_en", name, d), 32'(digEn), 32'hF);
            checkOutput($sformatf("%s/d%0d_blank_seg", name, d), 32'(segOut), 32'hFF);
            checkDigit(name, d, expSeg[d]);
        end
        advanceTo(15);
        checkOutput({name, "/no_early_done"}, 32'(frameDone), 32'h0);
        nextFrame(name);
    endtask

    initial begin
        vec_t vecs [9];
        vec_t v;
        int waited;

        vecs[0] = '{16'h0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[1] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[2] = '{16'h0042, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h99, 8'hA4}};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[4] = '{16'h0042, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'h99, 8'hA4}};
        vecs[5] = '{16'hABCD, 4'b0001, 1'b1, {8'h88, 8'h83, 8'hC6, 8'h21}};
        vecs[6] = '{16'h5678, 4'b1000, 1'b0, {8'h12, 8'h82, 8'hF8, 8'h80}};
        vecs[7] = '{16'hF09E, 4'b0000, 1'b1, {8'h8E, 8'hC0, 8'h90, 8'h86}};
        vecs[8] = '{16'h0100, 4'b0000, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'hC0}};

        // Reset state while rst is held, then the first blank cycle after release
        #2 rst = 1'b1;
        #1;
        checkOutput("reset/seg", 32'(segOut), 32'hFF);
        checkOutput("reset/dig", 32'(digEn), 32'hF);
        checkOutput("reset/frame_done", 32'(frameDone), 32'h0);
        tick();
        tick();
        checkOutput("reset_held/dig", 32'(digEn), 32'hF);
        rst = 1'b0;
        tick();
        checkOutput("release/blank_seg", 32'(segOut), 32'hFF);
        checkOutput("release/blank_dig", 32'(digEn), 32'hF);
        tick();
        checkOutput("release/first_dig", 32'(digEn), 32'hE);
        checkOutput("release/first_seg", 32'(segOut), 32'hC0);
        waitFrameDone("initial", waited);
        checkOutput("initial/frame_period", 32'(waited), 32'd14);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            nextFrame($sformatf("vec%0d_load", i));
            checkFrame($sformatf("vec%0d", i), vecs[i].seg);
        end

        for (int n = 0; n < 16; n++) begin
            v = '{16'(n), 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, decTab[n]}};
            applyStimulus(v);
            nextFrame($sformatf("dec%0h_load", n));
            checkFrame($sformatf("dec%0h", n), v.seg);
        end

        // Tear-free: a mid-frame load must not disturb the frame in progress
        v = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        applyStimulus(v);
        nextFrame("tear_setup");
        checkFrame("tear_f0", v.seg);
        checkDigit("tear_f1_pre", 0, 8'h99);
        valueIn = 16'h5678;
        load = 1'b1;
        tick();
        load = 1'b0;
        checkDigit("tear_f1_mid", 1, 8'hB0);
        checkDigit("tear_f1_mid", 2, 8'hA4);
        checkDigit("tear_f1_mid", 3, 8'hF9);
        // Load coincident with the boundary: pending 5678 shows next, 9ABC one frame later
        advanceTo(15);
        valueIn = 16'h9ABC;
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("coincident/frame_done", 32'(frameDone), 32'h1);
        ft = 0;
        checkFrame("coincident_f1", {8'h92, 8'h82, 8'hF8, 8'h80});
        checkFrame("coincident_f2", {8'h90, 8'h88, 8'h83, 8'hC6});

        // Reset in the middle of an enabled digit
        advanceTo(6);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset/seg", 32'(segOut), 32'hFF);
        checkOutput("midreset/dig", 32'(digEn), 32'hF);
        checkOutput("midreset/frame_done", 32'(frameDone), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("midreset_rel/blank_dig", 32'(digEn), 32'hF);
        tick();
        checkOutput("midreset_rel/dig0", 32'(digEn), 32'hE);
        checkOutput("midreset_rel/cleared_seg", 32'(segOut), 32'hC0);
        waitFrameDone("midreset", waited);
        checkOutput("midreset/frame_period", 32'(waited), 32'd14);

`ifdef SEVEN_SEG_DIM_EN
        begin
            int onCount;
            dimBright = 4'h4;
            for (int k = 0; k < 4; k++) tick();
            onCount = 0;
            for (int k = 0; k < 32; k++) begin
                tick();
                if (dimDig != 4'hF) onCount++;
            end
            checkOutput("dim4/on_cycles", 32'(onCount), 32'd8);
            dimBright = 4'h0;
            for (int k = 0; k < 4; k++) tick();
            onCount = 0;
            for (int k = 0; k < 32; k++) begin
                tick();
                if (dimDig != 4'hF) onCount++;
            end
            checkOutput("dim0/on_cycles", 32'(onCount), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Latches a packed hex value plus decimal points, then scans one digit at a time at a programmable refresh rate.
- Includes anti-ghosting blank time, optional leading-zero blanking, and tear-free frame-boundary updates.
- Sits between the timer/counter datapath and the board display pins; replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (< REFRESH_DIV).
- SEG_ACTIVE_LOW, 1, 1 = segment lines low-true, 0 = high-true.
- DIG_ACTIVE_LOW, 1, 1 = digit enables low-true, 0 = high-true.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- value_in  in  4*NUM_DIGITS  packed hex nibbles; digit 0 in bits [3:0]
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  capture value_in/dp_in into the shadow register
- blank_lz  in  1  enable leading-zero blanking
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dig_en  out  NUM_DIGITS  one-hot digit select, polarity per DIG_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (async, rst=1):
  - seg_out and dig_en are all off: 8'hFF / all ones when active-low.
  - frame_done=0; slot counter=0; digit index=0; shadow and display registers=0; pending=0.
- Slot counter counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the index advances.
  - Index wraps NUM_DIGITS-1 -> 0.
- Frame boundary (index NUM_DIGITS-1 -> 0):
  - frame_done=1 for exactly that one cycle.
  - If pending=1, the display register takes the shadow contents and pending clears.
- load=1: the shadow register takes value_in/dp_in and pending sets. The display does not change mid-frame.
- load and frame boundary in the same cycle:
  - The display takes the old shadow contents.
  - The new data goes into the shadow with pending=1 and appears one frame later.
- Within a slot:
  - Counter < BLANK_CYCLES: dig_en all off, seg_out all off.
  - Otherwise: dig_en asserts the bit for the current index only; seg_out = decode(nibble[index]) with dp = dp bit[index].
- seg_out and dig_en are registered, 1 cycle behind the counter/index state. No combinational path from inputs to outputs.
- Decode covers 0-F: 0,1,2,3,4,5,6,7,8,9,A,b,C,d,E,F (internal active-high, a=bit0).
- Leading-zero blanking (blank_lz=1):
  - Digit i (i>0) shows no segments if nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows dp_in.
  - Evaluation uses the display register, not the shadow.
- blank_lz is sampled combinationally each slot, so changes take effect at the next output update.
- Reset mid-frame forces outputs off on the next evaluation of rst (asynchronously). Scanning restarts at digit 0 with a full BLANK_CYCLES blank after release.

Optional Feature:
- Macro: SEVEN_SEG_DIM_EN.
- Defined:
  - Adds input port brightness [3:0].
  - Within the unblanked part of a slot, digit enable asserts only while (counter[3:0] < brightness). brightness=0 keeps the display dark; 15 gives 15/16 duty.
- Not defined: port absent; full duty after the blank period.

Decomposition:
- Package seven_seg_pkg:
  - Constants SEG_0..SEG_F and SEG_OFF (active-high 7-bit).
  - Localparam for the {dp,g..a} bit positions.
  - Function for polarity application.
- Sub-module seven_seg_hex_decoder: combinational, 4-bit nibble -> 7-bit active-high segments. Instantiated once on the muxed nibble.

Test Plan:
- Reset values: assert rst, NUM_DIGITS=4, active-low -> seg_out=8'hFF, dig_en=4'hF, frame_done=0. Release and hold 2 cycles -> still off (blank period).
- Scan timing: REFRESH_DIV=4, BLANK_CYCLES=1 -> each digit enabled 3 of 4 cycles. Order is 4'hE,4'hD,4'hB,4'h7. frame_done pulses every 16 cycles.
- Decode sweep: load each nibble 0..F into digit 0 -> seg_out matches the table, e.g. 0->8'hC0, 9->8'h90, A->8'h88, F->8'h8E.
- Tear-free load: load 16'h1234 mid-frame -> digits keep their old values until frame_done. Load coincident with frame_done -> new value shown one frame later.
- Leading-zero blanking: value 16'h0042, blank_lz=1 -> digits 3,2 show 8'hFF, digit1=8'h99, digit0=8'hA4. Value 16'h0000 -> only digit 0 shows 8'hC0.
- Dimming (SEVEN_SEG_DIM_EN): REFRESH_DIV=32, BLANK_CYCLES=0, brightness=4 -> digit enable active 4 of every 16 cycles. brightness=0 -> dig_en never asserted.
